// File: rtl/mouse_fmt_pkg.sv
// Shared types and ASCII constants for the mouse line formatter.
// MOUSE_FMT_CRLF_EN selects CR LF line endings (15 bytes) instead of LF only (14 bytes).
package mouse_fmt_pkg;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam logic [7:0] A_SPACE = 8'h20;
  localparam logic [7:0] A_PLUS  = 8'h2B;
  localparam logic [7:0] A_MINUS = 8'h2D;
  localparam logic [7:0] A_CR    = 8'h0D;
  localparam logic [7:0] A_LF    = 8'h0A;
  localparam logic [7:0] A_L     = 8'h4C;
  localparam logic [7:0] A_M     = 8'h4D;
  localparam logic [7:0] A_R     = 8'h52;
  localparam logic [7:0] A_DASH  = 8'h2D;
  localparam logic [7:0] A_ZERO  = 8'h30;

`ifdef MOUSE_FMT_CRLF_EN
  localparam int MSG_LEN = 15;
`else
  localparam int MSG_LEN = 14;
`endif
  localparam int IDX_W = $clog2(MSG_LEN);

  // 9-bit magnitude; -256 maps to 9'h100, which is why the top digit exists
  function automatic logic [8:0] mag9(input logic [8:0] v);
    return v[8] ? (~v + 9'd1) : v;
  endfunction

endpackage

// File: rtl/hex_to_ascii.sv
// Combinational nibble to uppercase hex ASCII digit.
module hex_to_ascii (
  input  logic [3:0] nib_i,
  output logic [7:0] asc_o
);

  always_comb begin
    asc_o = (nib_i < 4'd10) ? (8'h30 + {4'h0, nib_i}) : (8'h37 + {4'h0, nib_i});
  end

endmodule

// File: rtl/mouse_uart_formatter.sv
// Formats one PS/2 mouse packet per tick as an ASCII line into the UART tx FIFO.
// Line ending chosen by MOUSE_FMT_CRLF_EN (see mouse_fmt_pkg).
module mouse_uart_formatter
  import mouse_fmt_pkg::*;
#(
  parameter int DRP_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             m_done_tick,
  input  logic [2:0]       btn,
  input  logic [8:0]       xm,
  input  logic [8:0]       ym,
  input  logic             tx_full,
  output logic             wr_uart,
  output logic [7:0]       wr_data,
  output logic             busy,
  output logic [DRP_W-1:0] drop_cnt
);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [2:0]         btn_q, btn_d;
  logic [8:0]         xm_q, xm_d, ym_q, ym_d;
  logic [DRP_W-1:0]   drop_q, drop_d;

  logic [8:0]         xmag, ymag;
  logic [3:0][3:0]    nib;   // X1, X0, Y1, Y0
  logic [3:0][7:0]    asc;
  logic [7:0]         char_c;

  assign xmag = mag9(xm_q);
  assign ymag = mag9(ym_q);
  assign nib  = {ymag[3:0], ymag[7:4], xmag[3:0], xmag[7:4]};

  for (genvar g = 0; g < 4; g++) begin : g_hex
    hex_to_ascii u_hex (.nib_i(nib[g]), .asc_o(asc[g]));
  end

  always_comb begin
    char_c = A_LF;
    case (int'(idx_q))
      0:       char_c = btn_q[0] ? A_L : A_DASH;
      1:       char_c = btn_q[2] ? A_M : A_DASH;
      2:       char_c = btn_q[1] ? A_R : A_DASH;
      3, 8:    char_c = A_SPACE;
      4:       char_c = xm_q[8] ? A_MINUS : A_PLUS;
      5:       char_c = A_ZERO | {7'd0, xmag[8]};
      6:       char_c = asc[0];
      7:       char_c = asc[1];
      9:       char_c = ym_q[8] ? A_MINUS : A_PLUS;
      10:      char_c = A_ZERO | {7'd0, ymag[8]};
      11:      char_c = asc[2];
      12:      char_c = asc[3];
`ifdef MOUSE_FMT_CRLF_EN
      13:      char_c = A_CR;
`endif
      default: char_c = A_LF;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    btn_d   = btn_q;
    xm_d    = xm_q;
    ym_d    = ym_q;
    drop_d  = drop_q;
    wr_uart = 1'b0;
    wr_data = 8'h00;
    case (state_q)
      IDLE: begin
        if (m_done_tick) begin
          btn_d   = btn;
          xm_d    = xm;
          ym_d    = ym;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        wr_uart = !tx_full;
        wr_data = char_c;
        if (!tx_full) begin
          if (idx_q == IDX_W'(MSG_LEN - 1)) state_d = IDLE;
          else                              idx_d   = idx_q + 1'b1;
        end
        // captured packet stays frozen; late ticks only bump the counter
        if (m_done_tick && (drop_q != '1)) drop_d = drop_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      btn_q   <= '0;
      xm_q    <= '0;
      ym_q    <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      btn_q   <= btn_d;
      xm_q    <= xm_d;
      ym_q    <= ym_d;
      drop_q  <= drop_d;
    end
  end

  assign busy     = (state_q == SEND);
  assign drop_cnt = drop_q;

endmodule
